// File: rtl/reg_dump_uart.sv
// reg_dump_uart: snapshots the 32-entry register file and streams it out as 128 UART bytes, MSB byte first.
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dbg_regs [0:31],
    input  logic        start,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [4:0]    reg_idx_q, reg_idx_d;
    logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic          load;
    logic [31:0]   snap_q [0:31];
    logic [31:0]   cur_word;
    logic [7:0]    cur_byte;
    logic          bit_end, last_byte;

    assign cur_word  = snap_q[reg_idx_q];
    assign cur_byte  = 8'(cur_word >> {~byte_idx_q, 3'b000});
    assign bit_end   = baud_q == BW'(CLKS_PER_BIT - 1);
    assign last_byte = reg_idx_q == 5'd31 && byte_idx_q == 2'd3;

    always_comb begin
        state_d    = state_q;
        baud_d     = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        reg_idx_d  = reg_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load       = 1'b1;
                state_d    = START_BIT;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                bit_idx_d  = '0;
                byte_idx_d = '0;
                reg_idx_d  = '0;
            end
            START_BIT: if (bit_end) begin
                state_d = DATA_BITS;
                tx_d    = cur_byte[0];
            end
            DATA_BITS: if (bit_end) begin
                bit_idx_d = bit_idx_q + 3'd1;
                state_d   = (bit_idx_q == 3'd7) ? STOP_BIT : DATA_BITS;
                tx_d      = (bit_idx_q == 3'd7) ? 1'b1 : cur_byte[bit_idx_q + 3'd1];
            end
            STOP_BIT: if (bit_end) begin
                state_d                 = last_byte ? IDLE : START_BIT;
                tx_d                    = last_byte;
                busy_d                  = !last_byte;
                done_d                  = last_byte;
                {reg_idx_d, byte_idx_d} = last_byte ? {reg_idx_q, byte_idx_q} : {reg_idx_q, byte_idx_q} + 7'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            reg_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            reg_idx_q  <= reg_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // x0 is architecturally zero, so it is stored as zero regardless of the debug view
    always_ff @(posedge clk) begin
        if (load)
            for (int i = 0; i < 32; i++) snap_q[i] <= (i == 0) ? '0 : dbg_regs[i];
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
